// File: rtl/record_serializer.sv
`default_nettype none
// ============================================================================
// Module      : record_serializer
// Description : Queues wide timetag records and emits them MSB-first, one
//               byte per sample/sample_ack handshake; counts dropped records.
// Revision    : 1.0 - initial release
// ============================================================================
module record_serializer #(
    parameter int RECORD_BYTES = 6,
    parameter int DEPTH_LOG2   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [8*RECORD_BYTES-1:0] record,
    input  logic                      record_wr,
    output logic                      record_full,
    output logic [7:0]                sample,
    output logic                      sample_rdy,
    input  logic                      sample_ack,
    input  logic                      lost_clr,
    output logic [15:0]               lost_count,
    output logic                      busy
);

    localparam int W     = 8 * RECORD_BYTES;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IDX_W = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(RECORD_BYTES - 1);
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [W-1:0]          shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  full_q, full_d;
    logic                  busy_q, busy_d;
    logic [15:0]           lost_q, lost_d;

    logic push;
    logic pop;
    logic drop;
    logic fifo_nempty;
    logic take;

    always_comb begin
        push        = record_wr && !full_q;
        // A full FIFO rejects the write even if a pop frees a slot this edge.
        drop        = record_wr && full_q;
        fifo_nempty = (count_q != '0);
        take        = (state_q == S_SEND) && sample_ack;

        pop     = 1'b0;
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    idx_d   = LAST_IDX;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (take) begin
                    if (idx_q == '0) begin
                        // Reload straight from the FIFO so records run back to back.
                        if (fifo_nempty) begin
                            pop     = 1'b1;
                            shift_d = fifo_mem[rd_ptr_q];
                            idx_d   = LAST_IDX;
                        end else begin
                            shift_d = shift_q << 8;
                            state_d = S_IDLE;
                        end
                    end else begin
                        shift_d = shift_q << 8;
                        idx_d   = idx_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
        count_d  = count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
        full_d   = (count_d == DEPTH_CNT);
        busy_d   = (state_d == S_SEND) || (count_d != '0);

        lost_d = lost_q;
        if (lost_clr) begin
            lost_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (lost_q != 16'hFFFF)) begin
            lost_d = lost_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            lost_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            full_q   <= full_d;
            busy_q   <= busy_d;
            lost_q   <= lost_d;
        end
    end

    // Storage only; validity is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= record;
        end
    end

    assign sample      = shift_q[W-1 -: 8];
    assign sample_rdy  = (state_q == S_SEND);
    assign record_full = full_q;
    assign busy        = busy_q;
    assign lost_count  = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_record_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_record_serializer
// Description : Self-checking bench for record_serializer (vector table plus
//               directed corner sequences, byte scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_record_serializer;

    localparam int W = 48;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  record;
    logic          record_wr;
    logic          record_full;
    logic [7:0]    sample;
    logic          sample_rdy;
    logic          sample_ack;
    logic          lost_clr;
    logic [15:0]   lost_count;
    logic          busy;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [7:0]    exp_q [$];
    logic [3:0]    ack_pat = 4'b0000;
    int            ack_req = 0;
    int            ack_given = 0;
    logic [1:0]    phase = 2'd0;

    typedef struct {
        logic [W-1:0] rec;
        logic [3:0]   pat;
        logic [7:0]   first;
    } vec_t;

    vec_t          vecs [4];
    logic [W-1:0]  ov [6];

    always #5 clk = ~clk;

    record_serializer #(.RECORD_BYTES(6), .DEPTH_LOG2(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .record      (record),
        .record_wr   (record_wr),
        .record_full (record_full),
        .sample      (sample),
        .sample_rdy  (sample_rdy),
        .sample_ack  (sample_ack),
        .lost_clr    (lost_clr),
        .lost_count  (lost_count),
        .busy        (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [W-1:0] r);
        for (int b = 5; b >= 0; b--) exp_q.push_back(r[8*b +: 8]);
    endtask

    task automatic wr_one(input logic [W-1:0] r);
        record    = r;
        record_wr = 1'b1;
        tick();
        record_wr = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk({nm, "_rdy_end"}, 64'(sample_rdy), 64'd0);
        chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    // Ack driver: pending one-shot acks first, otherwise the repeating pattern.
    initial begin
        sample_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_req != ack_given) begin
                sample_ack = 1'b1;
                ack_given++;
            end else begin
                sample_ack = ack_pat[phase];
            end
            phase = phase + 2'd1;
        end
    end

    // Byte monitor: scoreboard on each accepted byte, stability while stalled.
    initial begin
        logic       hold_pend;
        logic [7:0] held;
        hold_pend = 1'b0;
        held      = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_rdy", 64'(sample_rdy), 64'd1);
                    chk("hold_val", 64'(sample), 64'(held));
                end
                if (sample_rdy && sample_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", 64'(sample), 64'hXX);
                    end else begin
                        chk("byte", 64'(sample), 64'(exp_q.pop_front()));
                    end
                    hold_pend = 1'b0;
                end else if (sample_rdy) begin
                    hold_pend = 1'b1;
                    held      = sample;
                end else begin
                    hold_pend = 1'b0;
                end
            end
        end
    end

    initial begin
        int           run;
        int           w;
        logic [W-1:0] ra;

        vecs[0] = '{rec: 48'h0123456789AB, pat: 4'b1111, first: 8'h01};
        vecs[1] = '{rec: 48'h0123456789AB, pat: 4'b1001, first: 8'h01};
        vecs[2] = '{rec: 48'hFEDCBA987654, pat: 4'b0101, first: 8'hFE};
        vecs[3] = '{rec: 48'h00FF00FF00FF, pat: 4'b1111, first: 8'h00};
        ov[0] = 48'hA1A1A1A1A1A1; ov[1] = 48'hB2B2B2B2B2B2; ov[2] = 48'hC3C3C3C3C3C3;
        ov[3] = 48'hD4D4D4D4D4D4; ov[4] = 48'hE5E5E5E5E5E5; ov[5] = 48'hF6F6F6F6F6F6;

        reset_n   = 1'b0;
        record    = '0;
        record_wr = 1'b0;
        lost_clr  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 64'(sample_rdy), 64'd0);
        chk("rst_sample", 64'(sample), 64'd0);
        chk("rst_full", 64'(record_full), 64'd0);
        chk("rst_lost", 64'(lost_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single records under several ack patterns, with latency check.
        for (int i = 0; i < 4; i++) begin
            ack_pat = vecs[i].pat;
            push_rec(vecs[i].rec);
            wr_one(vecs[i].rec);
            @(negedge clk);
            chk($sformatf("vec%0d_rdy_n", i), 64'(sample_rdy), 64'd0);
            chk($sformatf("vec%0d_busy_n", i), 64'(busy), 64'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_rdy_n1", i), 64'(sample_rdy), 64'd1);
            chk($sformatf("vec%0d_first", i), 64'(sample), 64'(vecs[i].first));
            drain($sformatf("vec%0d", i));
        end

        // Back-to-back records: twelve valid bytes with no gap.
        ack_pat = 4'b1111;
        push_rec(48'h111111111111);
        push_rec(48'h222222222222);
        wr_one(48'h111111111111);
        wr_one(48'h222222222222);
        run = 0;
        w   = 0;
        @(negedge clk);
        while (!sample_rdy && w < 10) begin
            @(negedge clk);
            w++;
        end
        while (sample_rdy && run < 20) begin
            run++;
            @(negedge clk);
        end
        chk("b2b_run", 64'(run), 64'd12);
        drain("b2b");

        // Overflow: four slots plus the shift register, sixth write dropped.
        ack_pat = 4'b0000;
        tick();
        for (int i = 0; i < 4; i++) wr_one(ov[i]);
        chk("ov_full4", 64'(record_full), 64'd0);
        wr_one(ov[4]);
        chk("ov_full5", 64'(record_full), 64'd1);
        chk("ov_lost5", 64'(lost_count), 64'd0);
        wr_one(ov[5]);
        chk("ov_full6", 64'(record_full), 64'd1);
        chk("ov_lost6", 64'(lost_count), 64'd1);
        for (int i = 0; i < 5; i++) push_rec(ov[i]);
        ack_pat = 4'b1111;
        drain("ov");
        chk("ov_full_end", 64'(record_full), 64'd0);
        chk("ov_lost_end", 64'(lost_count), 64'd1);

        // Saturation and clear behaviour of the lost counter.
        ack_pat = 4'b0000;
        tick();
        for (int i = 0; i < 5; i++) begin
            push_rec(ov[i] ^ 48'h0F0F0F0F0F0F);
            wr_one(ov[i] ^ 48'h0F0F0F0F0F0F);
        end
        chk("sat_full", 64'(record_full), 64'd1);
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        chk("sat_clr0", 64'(lost_count), 64'd0);
        record    = 48'hDEADBEEF0000;
        record_wr = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        chk("sat_fffe", 64'(lost_count), 64'hFFFE);
        tick();
        chk("sat_ffff", 64'(lost_count), 64'hFFFF);
        tick();
        tick();
        chk("sat_hold", 64'(lost_count), 64'hFFFF);
        lost_clr = 1'b1;
        tick();
        chk("clr_drop", 64'(lost_count), 64'd1);
        record_wr = 1'b0;
        tick();
        chk("clr_alone", 64'(lost_count), 64'd0);
        lost_clr = 1'b0;
        ack_pat  = 4'b1111;
        drain("sat");

        // Reset after three bytes of a record with two more queued.
        ack_pat = 4'b0000;
        tick();
        ra = 48'h5A6B7C8D9EAF;
        exp_q.push_back(ra[47:40]);
        exp_q.push_back(ra[39:32]);
        exp_q.push_back(ra[31:24]);
        wr_one(ra);
        wr_one(48'h123123123123);
        wr_one(48'h456456456456);
        tick();
        tick();
        ack_req = ack_req + 3;
        repeat (6) tick();
        chk("mid_consumed", 64'(exp_q.size()), 64'd0);
        chk("mid_rdy", 64'(sample_rdy), 64'd1);
        chk("mid_hold", 64'(sample), 64'(ra[23:16]));
        chk("mid_busy", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 64'(sample_rdy), 64'd0);
        chk("mid_rst_sample", 64'(sample), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_full", 64'(record_full), 64'd0);
        chk("mid_rst_lost", 64'(lost_count), 64'd0);
        ack_pat = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_rdy%0d", i), 64'(sample_rdy), 64'd0);
        end
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/record_serializer.md
Name: record_serializer

Overview:
- Sits between the timetag capture core and the FX2 bidirectional FIFO interface.
- Buffers wide timetag records in a small record FIFO and emits them MSB-first, one byte at a time, on the sample/sample_rdy/sample_ack byte handshake that the FX2 interface consumes.
- Counts records dropped on overflow so host software can detect data loss.

Parameters:
- RECORD_BYTES, 6: bytes per record; record width W = 8*RECORD_BYTES.
- DEPTH_LOG2, 2: log2 of record FIFO depth. Default depth is 4 records.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- record  input  W  record from capture core, byte RECORD_BYTES-1 (MSB) sent first.
- record_wr  input  1  one-cycle write strobe for record.
- record_full  output  1  FIFO holds 2^DEPTH_LOG2 records.
- sample  output  8  current byte to FX2 interface.
- sample_rdy  output  1  sample is valid.
- sample_ack  input  1  consumer takes sample this cycle.
- lost_clr  input  1  clear lost_count.
- lost_count  output  16  saturating count of dropped records.
- busy  output  1  FIFO non-empty or a record is being sent.

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, shift register 0, byte index 0, state IDLE. Outputs: sample=0, sample_rdy=0, record_full=0, lost_count=0, busy=0. Reset mid-record discards the partial record and all queued records.
- FIFO write:
  - record_wr=1 and count<depth: record stored at the same edge.
  - record_wr=1 and record_full=1: record dropped and lost_count increments, even if a pop happens on the same edge. Pop and write on the same edge with count<depth leaves count unchanged.
- record_full and busy are registered and reflect the post-edge count.
- lost_count saturates at 16'hFFFF.
  - lost_clr alone: next value 0.
  - lost_clr and a drop on the same edge: next value 1.
- Output FSM states: IDLE, SEND.
  - IDLE, FIFO non-empty: pop head into shift register, byte index = RECORD_BYTES-1, go to SEND, and assert sample_rdy with sample = head[W-1:W-8].
  - SEND, byte advances only on an edge where sample_rdy && sample_ack. The shift register shifts left 8 and the index decrements.
  - sample_ack while sample_rdy=0 is ignored.
  - sample and sample_rdy are registered and stay stable while sample_ack=0.
  - Ack of the last byte (index 0) with FIFO non-empty: load the next record on the same edge and stay in SEND. There is no bubble between records.
  - Ack of the last byte with FIFO empty: go to IDLE and deassert sample_rdy.
- Latency: record_wr sampled at edge N into an empty, idle block -> FIFO write at N, shift load at N+1, sample_rdy high after edge N+1. Minimum latency is 2 cycles.
- Throughput: one byte per cycle with sample_ack held high.
- Capacity: a record in the shift register has left the FIFO. Total buffering is depth+1 records.
- busy = (state==SEND) | FIFO non-empty.

Test Plan:
- Reset, one record: write 48'h0123456789AB with sample_ack=1. Required: sample_rdy rises 2 cycles after the write. Bytes 01,23,45,67,89,AB appear on 6 consecutive cycles, then sample_rdy=0 and busy=0.
- Backpressure: same record, sample_ack toggled 1,0,0,1,... Required: each byte is held stable while ack=0, and bytes stay in order with no duplication or loss.
- Back-to-back: write 48'h111111111111 and 48'h222222222222 on consecutive cycles, ack=1. Required: 12 consecutive valid bytes with no gap between 11 and 22.
- Overflow: ack=0, write 6 distinct records. Required:
  - records 1-5 accepted; record_full=1 after the 5th;
  - the 6th is dropped and lost_count=1;
  - after releasing ack, exactly records 1-5 are sent, in order.
- Saturation and clear: force 65537 drops. Required: lost_count=FFFF. Then lost_clr together with one drop gives lost_count=1; lost_clr alone gives 0.
- Reset mid-record: assert reset_n=0 after 3 bytes of a record with 2 records queued. Required: outputs go to reset values immediately, and after release no stale bytes are emitted.
